// File: rtl/sctr_axi_lsu_pkg.sv
// Shared encodings for the AXI4-Lite load/store unit.
package sctr_axi_lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV,
    ST_AR,
    ST_R,
    ST_WR,
    ST_B,
    ST_DONE,
    ST_ERR
  } lsu_st_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [2:0] AXI_PROT_DEF  = 3'b000;

endpackage

// File: rtl/sctr_axi_lsu_to_cnt.sv
// Response timeout counter: hit fires on the TIMEOUT-th enabled cycle since the last clear.
module sctr_axi_lsu_to_cnt #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [TO_W-1:0] LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  // TIMEOUT of zero leaves R/B waits unbounded
  assign hit = (TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/sctr_axi_lsu.sv
// Core load/store unit: turns core memory requests into AXI4-Lite master transactions
// and produces the pipeline advance enable, trap flag and bus error reports.
module sctr_axi_lsu
  import sctr_axi_lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_en_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_wem_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  input  logic                div_start_i,
  input  logic                div_ready_i,
  input  logic                iram_rstn_i,
  input  logic                trap_in_i,
  input  logic                trap_jump_i,
  input  logic                idex_mret_i,
  output logic                hx_valid,
  output logic                reg_we_o,
  output logic                csr_we_o,
  output logic                iram_rd_o,
  output logic                trap_stat_o,
  output logic                bus_err_o,
  output logic                bus_err_we_o,
  output logic [ADDR_W-1:0]   bus_err_addr_o,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  lsu_st_e st, st_nxt;

  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_wem;
  logic                req_we;
  logic                to_en, to_hit;

  assign to_en = (st == ST_R) || (st == ST_B);

  sctr_axi_lsu_to_cnt #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_to_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (st_nxt != st),
    .en   (to_en),
    .hit  (to_hit)
  );

  // Request fields are held in registers so AXI payloads stay stable under VALID
  assign m_axi_awaddr = req_addr;
  assign m_axi_araddr = req_addr;
  assign m_axi_wdata  = req_wdata;
  assign m_axi_wstrb  = req_wem;
  assign m_axi_awprot = AXI_PROT_DEF;
  assign m_axi_arprot = AXI_PROT_DEF;

  assign reg_we_o  = hx_valid;
  assign csr_we_o  = hx_valid;
  assign iram_rd_o = hx_valid | trap_jump_i;

  always_comb begin
    st_nxt   = st;
    hx_valid = 1'b0;
    case (st)
      ST_IDLE: begin
        hx_valid = ~(div_start_i | iram_rstn_i | trap_in_i | mem_en_i);
        if (trap_in_i)        st_nxt = ST_IDLE;
        else if (div_start_i) st_nxt = ST_DIV;
        else if (mem_en_i)    st_nxt = mem_we_i ? ST_WR : ST_AR;
      end
      ST_DIV: begin
        hx_valid = div_ready_i & ~trap_in_i;
        if (div_ready_i | trap_in_i) st_nxt = ST_IDLE;
      end
      ST_AR: if (m_axi_arready) st_nxt = ST_R;
      ST_R: begin
        if (m_axi_rvalid) st_nxt = (m_axi_rresp == AXI_RESP_OKAY) ? ST_DONE : ST_ERR;
        else if (to_hit)  st_nxt = ST_ERR;
      end
      // AW and W retire independently; move on once neither is still pending
      ST_WR: if ((~m_axi_awvalid | m_axi_awready) & (~m_axi_wvalid | m_axi_wready)) st_nxt = ST_B;
      ST_B: begin
        if (m_axi_bvalid) st_nxt = (m_axi_bresp == AXI_RESP_OKAY) ? ST_DONE : ST_ERR;
        else if (to_hit)  st_nxt = ST_ERR;
      end
      ST_DONE: begin
        hx_valid = ~trap_in_i;
        st_nxt   = ST_IDLE;
      end
      ST_ERR:  st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st             <= ST_IDLE;
      req_addr       <= '0;
      req_wdata      <= '0;
      req_wem        <= '0;
      req_we         <= 1'b0;
      m_axi_arvalid  <= 1'b0;
      m_axi_rready   <= 1'b0;
      m_axi_awvalid  <= 1'b0;
      m_axi_wvalid   <= 1'b0;
      m_axi_bready   <= 1'b0;
      mem_rdata_o    <= '0;
      trap_stat_o    <= 1'b0;
      bus_err_o      <= 1'b0;
      bus_err_we_o   <= 1'b0;
      bus_err_addr_o <= '0;
    end else begin
      st <= st_nxt;
      if (st == ST_IDLE && (st_nxt == ST_AR || st_nxt == ST_WR)) begin
        req_addr  <= mem_addr_i;
        req_wdata <= mem_wdata_i;
        req_wem   <= mem_wem_i;
        req_we    <= mem_we_i;
      end
      m_axi_arvalid <= (st_nxt == ST_AR);
      m_axi_rready  <= (st_nxt == ST_R);
      m_axi_bready  <= (st_nxt == ST_B);
      if (st == ST_IDLE && st_nxt == ST_WR) begin
        m_axi_awvalid <= 1'b1;
        m_axi_wvalid  <= 1'b1;
      end else begin
        if (m_axi_awready) m_axi_awvalid <= 1'b0;
        if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
      end
      if (st == ST_R && m_axi_rvalid) mem_rdata_o <= m_axi_rdata;
      bus_err_o <= (st_nxt == ST_ERR);
      if (st_nxt == ST_ERR) begin
        bus_err_addr_o <= req_addr;
        bus_err_we_o   <= req_we;
      end
      if (!trap_stat_o && trap_jump_i)                    trap_stat_o <= 1'b1;
      else if (trap_stat_o && idex_mret_i && hx_valid)    trap_stat_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sctr_axi_lsu.sv
// Scoreboarded bench for sctr_axi_lsu with a cycle-scripted AXI4-Lite slave.
module tb_sctr_axi_lsu;

  localparam int AW = 32, DW = 32, TO = 8, TOW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_en_i, mem_we_i;
  logic [AW-1:0] mem_addr_i;
  logic [DW-1:0] mem_wdata_i, mem_rdata_o;
  logic [3:0] mem_wem_i;
  logic div_start_i, div_ready_i, iram_rstn_i, trap_in_i, trap_jump_i, idex_mret_i;
  logic hx_valid, reg_we_o, csr_we_o, iram_rd_o, trap_stat_o;
  logic bus_err_o, bus_err_we_o;
  logic [AW-1:0] bus_err_addr_o;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;

  always #5 clk = ~clk;

  sctr_axi_lsu #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .TO_W(TOW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_en_i(mem_en_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_wem_i(mem_wem_i), .mem_rdata_o(mem_rdata_o),
    .div_start_i(div_start_i), .div_ready_i(div_ready_i), .iram_rstn_i(iram_rstn_i),
    .trap_in_i(trap_in_i), .trap_jump_i(trap_jump_i), .idex_mret_i(idex_mret_i),
    .hx_valid(hx_valid), .reg_we_o(reg_we_o), .csr_we_o(csr_we_o), .iram_rd_o(iram_rd_o),
    .trap_stat_o(trap_stat_o), .bus_err_o(bus_err_o), .bus_err_we_o(bus_err_we_o),
    .bus_err_addr_o(bus_err_addr_o),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int total = 0, bad = 0, ar_cnt = 0;

  typedef struct {
    bit          err;
    logic [31:0] data;
    logic [31:0] addr;
    bit          we;
  } exp_t;
  exp_t sb[$];
  exp_t me;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on load data and bus errors, and checks VALID stability
  logic rd_pend = 1'b0, p_ar = 1'b0, p_aw = 1'b0, p_w = 1'b0;
  logic [31:0] p_araddr = '0;
  always begin
    @(negedge clk); #2;
    if (rd_pend) begin
      rd_pend = 1'b0;
      if (sb.size() == 0) chk("sb_empty_rd", 1, 0);
      else begin
        me = sb.pop_front();
        chk("sb_kind_rd", me.err, 0);
        chk("sb_rdata", mem_rdata_o, me.data);
      end
    end
    if (bus_err_o) begin
      if (sb.size() == 0) chk("sb_empty_err", 1, 0);
      else begin
        me = sb.pop_front();
        chk("sb_kind_err", me.err, 1);
        chk("err_addr", bus_err_addr_o, me.addr);
        chk("err_we", bus_err_we_o, me.we);
      end
    end
    if (rst_n && rvalid && rready && rresp == 2'b00) rd_pend = 1'b1;
    if (arvalid && arready) ar_cnt++;
    if (p_ar) begin
      chk("ar_hold", arvalid, 1);
      chk("ar_addr_hold", araddr, p_araddr);
    end
    if (p_aw) chk("aw_hold", awvalid, 1);
    if (p_w)  chk("w_hold", wvalid, 1);
    p_ar     = rst_n && arvalid && !arready;
    p_aw     = rst_n && awvalid && !awready;
    p_w      = rst_n && wvalid && !wready;
    p_araddr = araddr;
  end

  task automatic ld_fast(input logic [31:0] a, input logic [31:0] d);
    int n0;
    n0 = ar_cnt;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      mem_en_i = (c == 0); mem_we_i = 1'b0; mem_addr_i = a;
      arready = 1'b1; rvalid = 1'b1; rdata = d; rresp = 2'b00;
      if (c == 0) sb.push_back('{err: 1'b0, data: d, addr: 32'h0, we: 1'b0});
      #1;
      chk("ld_hx", hx_valid, c == 3);
      if (c == 1) chk("ld_araddr", araddr, a);
    end
    arready = 1'b0; rvalid = 1'b0;
    chk("ld_ar_once", ar_cnt - n0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    mem_en_i = 0; mem_we_i = 0; mem_addr_i = '0; mem_wdata_i = '0; mem_wem_i = '0;
    div_start_i = 0; div_ready_i = 0; iram_rstn_i = 0; trap_in_i = 0; trap_jump_i = 0; idex_mret_i = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = '0; rresp = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rdata", mem_rdata_o, 0);
    chk("rst_trap_stat", trap_stat_o, 0);
    chk("rst_bus_err", bus_err_o, 0);
    chk("rst_hx_idle", hx_valid, 1);
    @(negedge clk); rst_n = 1'b1;

    // Back-to-back handshakes give a 3-cycle load
    ld_fast(32'h2000_0004, 32'hDEADBEEF);

    // Store with late AW and delayed B
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      mem_en_i = (c == 0); mem_we_i = 1'b1; mem_addr_i = 32'h1000;
      mem_wdata_i = 32'h1122_3344; mem_wem_i = 4'b0011;
      wready = (c == 1); awready = (c == 4); bvalid = (c == 6); bresp = 2'b00;
      #1;
      if (c >= 1) begin
        chk("st_awvalid", awvalid, c <= 4);
        chk("st_wvalid", wvalid, c == 1);
        chk("st_bready", bready, c == 5 || c == 6);
      end
      chk("st_hx", hx_valid, c == 7);
      if (c == 1) begin
        chk("st_wstrb", wstrb, 4'b0011);
        chk("st_wdata", wdata, 32'h1122_3344);
        chk("st_awaddr", awaddr, 32'h1000);
      end
    end
    wready = 0; awready = 0; bvalid = 0;

    // SLVERR on a load
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      mem_en_i = (c == 0); mem_we_i = 1'b0; mem_addr_i = 32'h40;
      arready = 1'b1; rvalid = 1'b1; rresp = 2'b10; rdata = 32'h0BAD;
      if (c == 0) sb.push_back('{err: 1'b1, data: 32'h0, addr: 32'h40, we: 1'b0});
      #1;
      chk("le_err", bus_err_o, c == 3);
      if (c <= 3) chk("le_hx", hx_valid, 0);
    end
    arready = 0; rvalid = 0; rresp = 0;

    // B never arrives: 8 cycles of bready then the error
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      mem_en_i = (c == 0); mem_we_i = 1'b1; mem_addr_i = 32'h80;
      mem_wdata_i = 32'h5555_AAAA; mem_wem_i = 4'hF;
      awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
      if (c == 0) sb.push_back('{err: 1'b1, data: 32'h0, addr: 32'h80, we: 1'b1});
      #1;
      if (c >= 1) chk("to_bready", bready, c >= 2 && c <= 9);
      chk("to_err", bus_err_o, c == 10);
      chk("to_hx", hx_valid, c == 11);
    end
    awready = 0; wready = 0;
    ld_fast(32'h44, 32'h1234_5678);

    // Trap while AR outstanding: transaction completes, no advance
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      mem_en_i = (c == 0); mem_we_i = 1'b0; mem_addr_i = 32'h300;
      trap_in_i = (c >= 1 && c <= 7);
      arready = (c == 4); rvalid = (c == 5); rdata = 32'hCAFE_0001; rresp = 2'b00;
      if (c == 0) sb.push_back('{err: 1'b0, data: 32'hCAFE_0001, addr: 32'h0, we: 1'b0});
      #1;
      chk("tr_arvalid", arvalid, c >= 1 && c <= 4);
      chk("tr_hx", hx_valid, c == 8);
    end
    trap_in_i = 0; arready = 0; rvalid = 0;

    // Divider stall
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      div_start_i = (c == 0); div_ready_i = (c == 5);
      #1;
      chk("dv_hx", hx_valid, c == 5);
    end
    @(negedge clk); div_ready_i = 0;

    // Trap status set/clear
    @(negedge clk); trap_in_i = 1; trap_jump_i = 1;
    #1; chk("tj_iram_rd", iram_rd_o, 1); chk("ts_pre", trap_stat_o, 0);
    @(negedge clk); trap_jump_i = 0; idex_mret_i = 1;
    #1; chk("ts_set", trap_stat_o, 1); chk("tj_iram_rd_off", iram_rd_o, 0);
    @(negedge clk); trap_in_i = 0;
    #1; chk("ts_hold_nohx", trap_stat_o, 1); chk("ts_hx", hx_valid, 1);
    @(negedge clk); idex_mret_i = 0;
    #1; chk("ts_clr", trap_stat_o, 0);

    // Reset in the middle of R
    @(negedge clk);
    mem_en_i = 1; mem_we_i = 0; mem_addr_i = 32'h500; arready = 1; rvalid = 0; trap_jump_i = 1;
    @(negedge clk); mem_en_i = 0; trap_jump_i = 0;
    #1; chk("mr_arvalid", arvalid, 1);
    @(negedge clk);
    #1; chk("mr_rready", rready, 1); chk("mr_ts", trap_stat_o, 1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("mr_rst_rready", rready, 0);
    chk("mr_rst_arvalid", arvalid, 0);
    chk("mr_rst_rdata", mem_rdata_o, 0);
    chk("mr_rst_ts", trap_stat_o, 0);
    chk("mr_rst_err_addr", bus_err_addr_o, 0);
    chk("mr_rst_err_we", bus_err_we_o, 0);
    chk("mr_rst_araddr", araddr, 0);
    rst_n = 1'b1; arready = 0;

    repeat (3) @(negedge clk);
    #3;
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
